// File: rtl/dpll_div_pkg.sv
// Shared definitions for the DPLL feedback-divider configuration path.
package dpll_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_EDGE = 3'd1,
    ST_APPLY     = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_DONE      = 3'd4
  } div_seq_state_t;

  localparam int DIV_BYPASS_CODE = 0;
  localparam int DIV_MIN_FACTOR  = 1;

endpackage

// File: rtl/div_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge strobe.
// A rise on async_i shows up on edge_o three clk_i cycles later.
module div_edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic edge_o
);

  logic [2:0] sync_reg;
  logic       edge_reg;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_reg <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[1:0], async_i};
      edge_reg <= sync_reg[1] & ~sync_reg[2];
    end
  end

  assign edge_o = edge_reg;

endmodule

// File: rtl/div_ratio_sequencer.sv
// Owns the divider factor/bypass configuration; applies retune requests on
// divided-output edges, slew-limited to STEP_MAX per step with settle time.
module div_ratio_sequencer
  import dpll_div_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int STEP_MAX     = 4,
  parameter int SETTLE_EDGES = 2,
  parameter int EDGE_TIMEOUT = 1024
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  input  logic [WIDTH-1:0] req_factor_i,
  output logic             req_ready_o,
  input  logic             abort_i,
  input  logic             div_i,
  output logic [WIDTH-1:0] div_factor_o,
  output logic             div_bypass_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int TW = $clog2(EDGE_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_EDGES + 1);

  localparam logic [WIDTH-1:0]        MIN_F  = WIDTH'(DIV_MIN_FACTOR);
  localparam logic [WIDTH-1:0]        BYP_F  = WIDTH'(DIV_BYPASS_CODE);
  localparam logic [WIDTH-1:0]        STEP_U = WIDTH'(STEP_MAX);
  localparam logic signed [WIDTH:0]   STEP_S = (WIDTH + 1)'(STEP_MAX);

  div_seq_state_t   state_reg, state_next;
  logic [WIDTH-1:0] factor_reg, factor_next;
  logic             bypass_reg, bypass_next;
  logic [WIDTH-1:0] target_reg, target_next;
  logic [SW-1:0]    settle_reg, settle_next;
  logic [TW-1:0]    tmo_reg, tmo_next, tmo_inc;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             ready_reg, ready_next;
  logic             busy_reg, busy_next;

  logic                    edge_stb;
  logic [WIDTH-1:0]        tf;
  logic signed [WIDTH:0]   diff;
  logic [WIDTH-1:0]        step_factor;
  logic                    req_match;
  logic                    tgt_match;
  logic                    tmo_hit;

  div_edge_sync u_edge_sync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (div_i),
    .edge_o  (edge_stb)
  );

  assign tf   = (target_reg == BYP_F) ? MIN_F : target_reg;
  // One extra bit keeps the signed difference exact for any factor pair.
  assign diff = $signed({1'b0, tf}) - $signed({1'b0, factor_reg});

  always_comb begin
    step_factor = tf;
    if (diff > STEP_S)
      step_factor = factor_reg + STEP_U;
    else if (diff < -STEP_S)
      step_factor = factor_reg - STEP_U;
  end

  assign req_match = (req_factor_i == BYP_F) ? bypass_reg
                                             : (!bypass_reg && factor_reg == req_factor_i);
  assign tgt_match = (target_reg == BYP_F) ? bypass_reg
                                           : (!bypass_reg && factor_reg == target_reg);

  assign tmo_inc = tmo_reg + 1'b1;
  assign tmo_hit = (tmo_inc == TW'(EDGE_TIMEOUT));

  always_comb begin
    state_next  = state_reg;
    factor_next = factor_reg;
    bypass_next = bypass_reg;
    target_next = target_reg;
    settle_next = settle_reg;
    tmo_next    = tmo_reg;
    err_next    = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i && ready_reg) begin
          if (req_match) begin
            state_next = ST_DONE;
          end else begin
            target_next = req_factor_i;
            tmo_next    = '0;
            state_next  = ST_WAIT_EDGE;
          end
        end
      end

      ST_WAIT_EDGE: begin
        if (abort_i) begin
          state_next = ST_IDLE;
        end else if (edge_stb) begin
          tmo_next   = '0;
          state_next = ST_APPLY;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_next = tmo_inc;
        end
      end

      ST_APPLY: begin
        if (abort_i) begin
          state_next = ST_IDLE;
        end else begin
          if (bypass_reg && target_reg != BYP_F) begin
            bypass_next = 1'b0;
            factor_next = MIN_F;
          end else if (factor_reg != tf) begin
            factor_next = step_factor;
          end else if (target_reg == BYP_F) begin
            bypass_next = 1'b1;
            factor_next = MIN_F;
          end
          settle_next = SW'(SETTLE_EDGES);
          tmo_next    = '0;
          state_next  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (abort_i) begin
          state_next = ST_IDLE;
        end else if (edge_stb) begin
          tmo_next    = '0;
          settle_next = settle_reg - 1'b1;
          if (settle_reg == SW'(1))
            state_next = tgt_match ? ST_DONE : ST_APPLY;
        end else if (tmo_hit) begin
          err_next   = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tmo_next = tmo_inc;
        end
      end

      ST_DONE: state_next = ST_IDLE;

      default: state_next = ST_IDLE;
    endcase

    done_next  = (state_next == ST_DONE);
    ready_next = (state_next == ST_IDLE);
    busy_next  = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg  <= ST_IDLE;
      factor_reg <= MIN_F;
      bypass_reg <= 1'b1;
      target_reg <= BYP_F;
      settle_reg <= '0;
      tmo_reg    <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      factor_reg <= factor_next;
      bypass_reg <= bypass_next;
      target_reg <= target_next;
      settle_reg <= settle_next;
      tmo_reg    <= tmo_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      ready_reg  <= ready_next;
      busy_reg   <= busy_next;
    end
  end

  assign div_factor_o = factor_reg;
  assign div_bypass_o = bypass_reg;
  assign req_ready_o  = ready_reg;
  assign busy_o       = busy_reg;
  assign done_o       = done_reg;
  assign err_o        = err_reg;

endmodule

// File: tb/tb_div_ratio_sequencer.sv
// Directed bench for div_ratio_sequencer: ramps, repeat, bypass, abort,
// edge timeout and held-request handshake.
module tb_div_ratio_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic [7:0] req_factor;
  logic       req_ready;
  logic       abort;
  logic       div_i;
  logic [7:0] div_factor;
  logic       div_bypass;
  logic       busy, done, err;

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic       div_run;
  int         div_cnt = 0;

  logic [8:0] chg_cfg[$];
  int         chg_t[$];
  logic [8:0] prev_cfg;
  int         done_cnt;

  div_ratio_sequencer #(
    .WIDTH(8), .STEP_MAX(4), .SETTLE_EDGES(2), .EDGE_TIMEOUT(64)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_n),
    .req_valid_i  (req_valid),
    .req_factor_i (req_factor),
    .req_ready_o  (req_ready),
    .abort_i      (abort),
    .div_i        (div_i),
    .div_factor_o (div_factor),
    .div_bypass_o (div_bypass),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Free-running divided clock: period 8 clk cycles while enabled.
  always @(negedge clk) begin
    if (div_run) begin
      div_cnt = div_cnt + 1;
      if (div_cnt == 4) begin
        div_cnt = 0;
        div_i   = ~div_i;
      end
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (reset_n) begin
      if ({div_bypass, div_factor} !== prev_cfg) begin
        chg_cfg.push_back({div_bypass, div_factor});
        chg_t.push_back(cyc);
        prev_cfg = {div_bypass, div_factor};
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    chg_cfg.delete();
    chg_t.delete();
    prev_cfg = {div_bypass, div_factor};
    done_cnt = 0;
  endtask

  // Returns on the negedge of the cycle after acceptance (valid dropped there).
  task automatic send(input logic [7:0] f, output int t_acc);
    int n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_factor = f;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept_bound", 32'(n < 500), 1);
    t_acc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int maxc, output int t);
    int n = 0;
    while (!(done || err) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_bound", 32'(n < maxc), 1);
    t = cyc;
  endtask

  logic [8:0] exp_up  [4] = '{9'h001, 9'h005, 9'h009, 9'h00a};
  logic [8:0] exp_dn  [4] = '{9'h006, 9'h002, 9'h001, 9'h101};
  logic [8:0] exp_ab  [3] = '{9'h001, 9'h005, 9'h009};

  initial begin
    int t, td, n, rdy_bad;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_factor = '0;
    abort      = 1'b0;
    div_i      = 1'b0;
    div_run    = 1'b1;
    prev_cfg   = '0;
    done_cnt   = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_bypass", div_bypass, 1);
    chk("rst_factor", div_factor, 1);
    chk("rst_ready",  req_ready, 1);
    chk("rst_busy",   busy, 0);
    chk("rst_done",   done, 0);
    chk("rst_err",    err, 0);
    reset_n = 1'b1;
    @(negedge clk);
    clear_mon();

    // Ramp-up to 10
    send(8'd10, t);
    chk("up_busy", busy, 1);
    wait_done(600, td);
    @(negedge clk);
    chk("up_ready_after", req_ready, 1);
    chk("up_done_cnt", done_cnt, 1);
    chk("up_nchg", chg_cfg.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < chg_cfg.size()) chk($sformatf("up_cfg%0d", i), chg_cfg[i], exp_up[i]);
    for (int i = 1; i < 4; i++)
      if (i < chg_t.size()) chk($sformatf("up_gap%0d", i), chg_t[i] - chg_t[i-1], 16);
    if (chg_t.size() == 4) chk("up_done_lat", td - chg_t[3], 15);

    // Repeat request
    clear_mon();
    send(8'd10, t);
    chk("rep_done", done, 1);
    chk("rep_ready_low", req_ready, 0);
    @(negedge clk);
    chk("rep_ready", req_ready, 1);
    chk("rep_done_low", done, 0);
    chk("rep_nchg", chg_cfg.size(), 0);
    chk("rep_factor", div_factor, 10);
    chk("rep_bypass", div_bypass, 0);

    // Ramp to bypass
    clear_mon();
    send(8'd0, t);
    wait_done(600, td);
    @(negedge clk);
    chk("byp_done_cnt", done_cnt, 1);
    chk("byp_nchg", chg_cfg.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < chg_cfg.size()) chk($sformatf("byp_cfg%0d", i), chg_cfg[i], exp_dn[i]);

    // Abort mid-ramp
    clear_mon();
    send(8'd20, t);
    n = 0;
    while (div_factor !== 8'd9 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ab_reach9_bound", 32'(n < 400), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    chk("ab_factor", div_factor, 9);
    chk("ab_bypass", div_bypass, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ready", req_ready, 1);
    chk("ab_done_cnt", done_cnt, 0);
    chk("ab_nchg", chg_cfg.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < chg_cfg.size()) chk($sformatf("ab_cfg%0d", i), chg_cfg[i], exp_ab[i]);
    send(8'd9, t);
    chk("ab_repeat_done", done, 1);

    // Edge timeout
    div_run = 1'b0;
    div_i   = 1'b0;
    repeat (10) @(negedge clk);
    clear_mon();
    send(8'd30, t);
    n = 0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_bound", 32'(n < 200), 1);
    chk("tmo_latency", cyc - t, 65);
    chk("tmo_factor", div_factor, 9);
    chk("tmo_bypass", div_bypass, 0);
    @(negedge clk);
    chk("tmo_err_pulse", err, 0);
    chk("tmo_ready", req_ready, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_done_cnt", done_cnt, 0);
    chk("tmo_nchg", chg_cfg.size(), 0);

    // Held request during a sequence
    div_run = 1'b1;
    clear_mon();
    send(8'd13, t);
    req_valid  = 1'b1;
    req_factor = 8'd12;
    n = 0;
    rdy_bad = 0;
    while (!done && n < 400) begin
      if (req_ready) rdy_bad++;
      @(negedge clk);
      n++;
    end
    chk("hs_bound", 32'(n < 400), 1);
    chk("hs_ready_held_low", rdy_bad, 0);
    chk("hs_ready_at_done", req_ready, 0);
    chk("hs_factor13", div_factor, 13);
    @(negedge clk);
    chk("hs_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("hs_busy_second", busy, 1);
    wait_done(400, td);
    @(negedge clk);
    chk("hs_factor12", div_factor, 12);
    chk("hs_done_cnt", done_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ratio_sequencer.md
# div_ratio_sequencer

Sequencer that owns the configuration inputs of the DPLL feedback frequency divider: `divFactor` and `bypass`. It accepts retune requests over a valid/ready handshake and applies each change only on a rising edge of the divided output. Large ratio changes are slew-limited into steps of at most STEP_MAX, with a settle interval after every step, so the loop is not knocked out of lock. It sits between the DPLL control logic and the divider instance and provides the only path that changes divider configuration.

## Interface
- WIDTH, 8: divide-factor width; matches the divider factor port.
- STEP_MAX, 4: maximum factor change per applied step; must be ≥1.
- SETTLE_EDGES, 2: divided-output rising edges to wait after each step; must be ≥1.
- EDGE_TIMEOUT, 1024: maximum clk_i cycles without a divided-output edge before aborting with an error; must be ≥4.
- clk_i  in  1  system clock.
- reset_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  retune request valid.
- req_factor_i  in  WIDTH  target factor; 0 means bypass mode.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- abort_i  in  1  cancel the sequence in progress.
- div_i  in  1  divider output (`divided_o`); may be asynchronous while the divider is in bypass.
- div_factor_o  out  WIDTH  drives the divider factor input.
- div_bypass_o  out  1  drives the divider bypass input.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse: target reached.
- err_o  out  1  one-cycle pulse: edge timeout.

## Operation
- **Reset values:** div_bypass_o=1, div_factor_o=1, req_ready_o=1, busy_o=0, done_o=0, err_o=0, state=IDLE.
- **Invariant:** whenever div_bypass_o=1, div_factor_o=1.
- **Effective target:** tf = (target==0) ? 1 : target.
- **Edge detect:** div_i passes through a 2-flop synchronizer followed by a rising-edge detector. A pin rise becomes the internal `edge` strobe 3 cycles later.
- **FSM states:** IDLE, WAIT_EDGE, APPLY, SETTLE, DONE.
- **IDLE:** req_ready_o=1.
  - When a request is accepted and its target equals the current configuration (same bypass state, and same factor when not bypassed), go to DONE without waiting for any edge.
  - Otherwise latch the target and go to WAIT_EDGE.
- **WAIT_EDGE:** on `edge`, go to APPLY.
- **APPLY (1 cycle):** registers load at the end of this cycle. The first matching rule applies:
  - bypass=1 and target≠0: clear bypass; factor stays 1.
  - factor≠tf: factor moves toward tf by min(|tf−factor|, STEP_MAX). The difference is computed in WIDTH+1-bit signed arithmetic; no wrap-around.
  - factor==tf and target==0: set bypass.
  - After APPLY, load the settle counter with SETTLE_EDGES and go to SETTLE.
- **SETTLE:** decrement the counter on each `edge`. When the counter reaches 0 on an edge:
  - if the configuration equals the target, go to DONE;
  - otherwise go directly to APPLY.
- **DONE (1 cycle):** done_o=1, then go to IDLE.
- **abort_i:** in WAIT_EDGE, APPLY or SETTLE, return to IDLE at the next edge of clk_i.
  - Configuration is frozen at its current value; any APPLY update in that same cycle is suppressed.
  - No done_o pulse. abort_i is ignored in IDLE.
- **Timeout:** a cycle counter is cleared on entry to WAIT_EDGE or SETTLE and on every `edge`. If it reaches EDGE_TIMEOUT, pulse err_o, go to IDLE, and leave the configuration unchanged.
- **abort_i and timeout in the same cycle:** abort wins; no err_o.

## Timing
- All outputs are registered.
- Request accepted at cycle T with a target equal to the current configuration: done_o is high at T+1; req_ready_o is high again at T+2.
- Request accepted at cycle T with a different target: busy_o is high from T+1.
- Each new factor appears on div_factor_o one cycle after its APPLY cycle.
- Back-to-back requests are allowed: a request may be accepted in the first IDLE cycle after DONE.
- Configuration changes only on cycles following an APPLY. No other path alters div_factor_o or div_bypass_o.
- Reset asserted mid-sequence restores the reset values immediately (asynchronously).

## Structure
- **Package `dpll_div_pkg`:**
  - state enum `div_seq_state_t`;
  - constants `DIV_BYPASS_CODE` (=0) and `DIV_MIN_FACTOR` (=1).
- **Sub-module `div_edge_sync`:** 2-flop synchronizer plus rising-edge strobe, reusable by lock-detect logic.
- **Top level:** FSM, step arithmetic, settle counter and timeout counter.

## Test plan
- **Reset ramp-up** (STEP_MAX=4, SETTLE_EDGES=2, div_i toggling): after reset, request 10 → bypass cleared (factor 1), then factors 5, 9, 10, each applied only after 2 edges; done_o fires once.
- **Repeat request:** request 10 while already at 10 → done_o one cycle after acceptance; outputs unchanged; no edge waited.
- **Ramp to bypass:** from 10, request 0 → factors 6, 2, 1, then div_bypass_o=1 with factor 1.
- **Abort mid-ramp:** from 1, request 20; assert abort_i after factor reaches 9 → IDLE, factor holds 9, no done_o; a following request 9 completes immediately.
- **Edge timeout** (EDGE_TIMEOUT=64): hold div_i low and request 30 → err_o pulses 64 cycles after entering WAIT_EDGE; configuration unchanged; req_ready_o high on the next cycle.
- **Handshake during a sequence:** hold req_valid_i high during a sequence → req_ready_o stays 0; the held request is accepted in the first IDLE cycle after done_o.
